// File: rtl/fe_fifo_reader.sv
// Capture FIFO reader: pops 18-bit entries and presents them as three bytes
// on the USB register read path, with an entry counter and an underflow flag.
module fe_fifo_reader #(
    parameter int pWORD_COUNT_WIDTH = 16
) (
    input  logic                         cwusb_clk,
    input  logic                         reset_n,
    input  logic [17:0]                  I_fifo_dout,
    input  logic                         I_fifo_empty,
    output logic                         O_fifo_rd,
    input  logic                         I_fifo_overflow_blocked,
    input  logic                         I_byte_rd,
    input  logic                         I_flush,
    output logic [7:0]                   O_byte,
    output logic                         O_byte_valid,
    output logic                         O_underflow,
    output logic [pWORD_COUNT_WIDTH-1:0] O_word_count
);

    // state   | meaning
    // S_EMPTY | no entry held
    // S_WAIT  | FIFO read issued last cycle, data arrives now
    // S_B0..2 | byte index 0..2 of the held entry presented
    typedef enum logic [2:0] {
        S_EMPTY = 3'd0,
        S_WAIT  = 3'd1,
        S_B0    = 3'd2,
        S_B1    = 3'd3,
        S_B2    = 3'd4
    } state_t;

    localparam logic [pWORD_COUNT_WIDTH-1:0] C_CNT_ONE = {{(pWORD_COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                         r_state;
    logic [17:0]                    r_word;
    logic                           r_flag;
    logic                           r_run;
    logic                           r_underflow;
    logic [pWORD_COUNT_WIDTH-1:0]   r_count;

    logic                           w_byte_valid;
    logic                           w_fifo_rd;
    logic [7:0]                     w_byte;

    assign w_byte_valid = (r_state == S_B0) || (r_state == S_B1) || (r_state == S_B2);

    // Read decision is combinational so the next entry is requested in the
    // same cycle the last byte is consumed; the run bit keeps it quiet in reset.
    assign w_fifo_rd = r_run && !I_flush && !I_fifo_empty &&
                       ((r_state == S_EMPTY) || ((r_state == S_B2) && I_byte_rd));

    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            S_B0:    w_byte = r_word[7:0];
            S_B1:    w_byte = r_word[15:8];
            S_B2:    w_byte = {r_flag, 5'b00000, r_word[17:16]};
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_EMPTY;
            r_word      <= 18'h0;
            r_flag      <= 1'b0;
            r_run       <= 1'b0;
            r_underflow <= 1'b0;
            r_count     <= '0;
        end else begin
            r_run <= 1'b1;
            if (I_flush) begin
                r_state     <= S_EMPTY;
                r_underflow <= 1'b0;
                r_count     <= '0;
            end else begin
                if (I_byte_rd && !w_byte_valid) begin
                    r_underflow <= 1'b1;
                end
                case (r_state)
                    S_EMPTY: begin
                        if (w_fifo_rd) r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_word  <= I_fifo_dout;
                        r_flag  <= I_fifo_overflow_blocked;
                        if (r_count != '1) r_count <= r_count + C_CNT_ONE;
                        r_state <= S_B0;
                    end
                    S_B0: begin
                        if (I_byte_rd) r_state <= S_B1;
                    end
                    S_B1: begin
                        if (I_byte_rd) r_state <= S_B2;
                    end
                    S_B2: begin
                        if (I_byte_rd) r_state <= w_fifo_rd ? S_WAIT : S_EMPTY;
                    end
                    default: r_state <= S_EMPTY;
                endcase
            end
        end
    end

    assign O_fifo_rd    = w_fifo_rd;
    assign O_byte       = w_byte;
    assign O_byte_valid = w_byte_valid;
    assign O_underflow  = r_underflow;
    assign O_word_count = r_count;

endmodule

// File: tb/tb_fe_fifo_reader.sv
// Self-checking bench for fe_fifo_reader: behavioural FIFO feeding the DUT,
// byte scoreboard filled when entries are queued and drained on each host read.
module tb_fe_fifo_reader;

    localparam int CW = 4;

    logic          cwusb_clk;
    logic          reset_n;
    logic [17:0]   fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd;
    logic          ovf_blocked;
    logic          byte_rd;
    logic          flush;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          underflow;
    logic [CW-1:0] word_count;

    int checks;
    int failures;
    int rd_pulses;

    logic [17:0] fifo_q[$];
    logic [7:0]  exp_q[$];

    fe_fifo_reader #(.pWORD_COUNT_WIDTH(CW)) dut (
        .cwusb_clk               (cwusb_clk),
        .reset_n                 (reset_n),
        .I_fifo_dout             (fifo_dout),
        .I_fifo_empty            (fifo_empty),
        .O_fifo_rd               (fifo_rd),
        .I_fifo_overflow_blocked (ovf_blocked),
        .I_byte_rd               (byte_rd),
        .I_flush                 (flush),
        .O_byte                  (byte_out),
        .O_byte_valid            (byte_valid),
        .O_underflow             (underflow),
        .O_word_count            (word_count)
    );

    initial cwusb_clk = 1'b0;
    always #5 cwusb_clk = ~cwusb_clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Standard (non-FWFT) FIFO: data appears the cycle after the read strobe.
    always @(posedge cwusb_clk) begin
        if (fifo_rd) begin
            if (fifo_q.size() == 0) begin
                chk("rd_when_empty", 1, 0);
            end else begin
                fifo_dout <= fifo_q.pop_front();
                rd_pulses <= rd_pulses + 1;
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic cyc();
        @(posedge cwusb_clk);
        #1;
    endtask

    task automatic push_fifo(input logic [17:0] w, input logic expect_it, input logic f);
        logic [7:0] b2;
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
        if (expect_it) begin
            b2 = {f, 5'b00000, w[17:16]};
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(b2);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!byte_valid && n < 10) begin
            cyc();
            n++;
        end
        if (!byte_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic consume();
        wait_valid();
        if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
        else chk("byte", 32'(byte_out), 32'(exp_q.pop_front()));
        byte_rd = 1'b1;
        cyc();
        byte_rd = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    initial begin
        int nbytes;
        int bubbles;
        int n;
        checks = 0; failures = 0; rd_pulses = 0;
        reset_n = 1'b0; fifo_dout = 18'h0; fifo_empty = 1'b1;
        ovf_blocked = 1'b0; byte_rd = 1'b0; flush = 1'b0;
        cyc(); cyc();
        chk("rst_fifo_rd", 32'(fifo_rd), 0);
        chk("rst_byte", 32'(byte_out), 0);
        chk("rst_valid", 32'(byte_valid), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_count", 32'(word_count), 0);
        reset_n = 1'b1;
        cyc(); cyc();

        // single entry, basic byte order and latency
        push_fifo(18'h2A5C3, 1'b1, 1'b0);
        #1 chk("t1_rd", 32'(fifo_rd), 1);
        cyc();
        chk("t1_wait_valid", 32'(byte_valid), 0);
        chk("t1_rd_once", 32'(fifo_rd), 0);
        cyc();
        chk("t1_valid", 32'(byte_valid), 1);
        consume(); consume(); consume();
        chk("t1_done_valid", 32'(byte_valid), 0);
        chk("t1_count", 32'(word_count), 1);

        // three back-to-back entries
        do_flush();
        rd_pulses = 0;
        push_fifo(18'h1_0102, 1'b1, 1'b0);
        push_fifo(18'h2_0304, 1'b1, 1'b0);
        push_fifo(18'h3_0506, 1'b1, 1'b0);
        nbytes = 0; bubbles = 0; n = 0;
        while (nbytes < 9 && n < 40) begin
            if (byte_valid) begin
                if (exp_q.size() == 0) chk("t2_scoreboard_empty", 1, 0);
                else chk("t2_byte", 32'(byte_out), 32'(exp_q.pop_front()));
                byte_rd = 1'b1;
                nbytes++;
            end else begin
                byte_rd = 1'b0;
                if (nbytes > 0) bubbles++;
            end
            cyc();
            n++;
        end
        byte_rd = 1'b0;
        chk("t2_nbytes", nbytes, 9);
        chk("t2_bubbles", bubbles, 2);
        chk("t2_rd_pulses", rd_pulses, 3);
        chk("t2_count", 32'(word_count), 3);
        chk("t2_underflow", 32'(underflow), 0);

        // underflow on empty, cleared by flush
        byte_rd = 1'b1;
        #1 chk("t3_no_rd", 32'(fifo_rd), 0);
        cyc();
        byte_rd = 1'b0;
        chk("t3_underflow", 32'(underflow), 1);
        chk("t3_valid", 32'(byte_valid), 0);
        do_flush();
        chk("t3_underflow_clr", 32'(underflow), 0);

        // overflow-blocked flag captured at load time
        ovf_blocked = 1'b1;
        push_fifo(18'h3_1234, 1'b1, 1'b1);
        wait_valid();
        ovf_blocked = 1'b0;
        consume(); consume(); consume();
        chk("t4_count", 32'(word_count), 1);

        // flush while the read is in flight
        push_fifo(18'h2_BEEF, 1'b0, 1'b0);
        push_fifo(18'h1_CAFE, 1'b1, 1'b0);
        cyc();
        flush = 1'b1;
        #1 chk("t5_no_rd", 32'(fifo_rd), 0);
        cyc();
        flush = 1'b0;
        chk("t5_valid", 32'(byte_valid), 0);
        chk("t5_count", 32'(word_count), 0);
        consume(); consume(); consume();
        chk("t5_count_after", 32'(word_count), 1);

        // counter saturation
        do_flush();
        for (int i = 0; i < 17; i++) push_fifo(18'($urandom_range(0, 18'h3FFFF)), 1'b1, 1'b0);
        for (int i = 0; i < 51; i++) consume();
        chk("t6_count_sat", 32'(word_count), 15);

        // async reset in the middle of an entry
        push_fifo(18'h0_5A5A, 1'b1, 1'b0);
        push_fifo(18'h0_1111, 1'b1, 1'b0);
        consume();
        chk("t6_in_b1", 32'(byte_out), 32'h5A);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(byte_valid), 0);
        chk("t6_rst_byte", 32'(byte_out), 0);
        chk("t6_rst_count", 32'(word_count), 0);
        chk("t6_rst_underflow", 32'(underflow), 0);
        chk("t6_rst_fifo_rd", 32'(fifo_rd), 0);
        exp_q.delete();
        fifo_q.delete();
        fifo_empty = 1'b1;
        cyc();
        reset_n = 1'b1;
        cyc(); cyc();
        chk("t6_post_count", 32'(word_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
